reorder_buffer_mp: RTL and testbench

REORDER_BUFFER_MP -- requirements
Module: reorder_buffer_mp

---
 rtl/reorder_buffer_mp.sv | 195 +++++++++++++++++++
 tb/tb_reorder_buffer_mp.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mp.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_mp
// Purpose  : Circular reorder buffer with NUM_WB writeback ports, two operand
//            lookup ports with writeback bypass, in-order commit and a
//            precise-exception drain on committing a faulting entry.
// Ports    : clk, rst_n (sync, active-low)
//            alloc_*  : allocation handshake from decode, alloc_tag = tail
//            wb_*     : packed per-port writeback (port p in slice p)
//            rd_*     : combinational operand lookups
//            commit_* : head-entry view and commit handshake
//            flush    : discard all entries
//            count/empty/full : occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer_mp #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32,
    parameter int NUM_WB = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [4:0]               alloc_rd,
    input  logic [31:0]              alloc_pc,
    output logic [IDX_W-1:0]         alloc_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB-1:0]        wb_exc,
    input  logic [NUM_WB*IDX_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic [IDX_W-1:0]         rd_tag0,
    input  logic [IDX_W-1:0]         rd_tag1,
    output logic [DATA_W-1:0]        rd_data0,
    output logic [DATA_W-1:0]        rd_data1,
    output logic                     rd_ready0,
    output logic                     rd_ready1,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [4:0]               commit_rd,
    output logic [DATA_W-1:0]        commit_data,
    output logic [31:0]              commit_pc,
    output logic [IDX_W-1:0]         commit_tag,
    output logic                     commit_exc,
    input  logic                     flush,
    output logic [IDX_W:0]           count,
    output logic                     empty,
    output logic                     full
);

    localparam logic [IDX_W:0]   c_depth     = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   c_count_one = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_ptr_one   = IDX_W'(1);

    // Entry storage
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_exc;
    logic [4:0]        r_rd   [DEPTH];
    logic [31:0]       r_pc   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;

    // Unpacked writeback ports
    logic [IDX_W-1:0]  w_wb_tag [NUM_WB];
    logic [DATA_W-1:0] w_wb_dat [NUM_WB];

    // Per-entry resolved writeback (lowest port wins)
    logic [DEPTH-1:0]  w_wb_hit;
    logic [DEPTH-1:0]  w_wb_exc;
    logic [DATA_W-1:0] w_wb_val [DEPTH];

    // Lookup results
    logic [IDX_W-1:0]  w_lk_tag [2];
    logic [1:0]        w_lk_rdy;
    logic [DATA_W-1:0] w_lk_dat [2];

    logic w_empty;
    logic w_full;
    logic w_commit_valid;
    logic w_commit_fire;
    logic w_alloc_fire;
    logic w_drain;

    for (genvar p = 0; p < NUM_WB; p++) begin : g_wb_unpack
        assign w_wb_tag[p] = wb_tag[p*IDX_W +: IDX_W];
        assign w_wb_dat[p] = wb_data[p*DATA_W +: DATA_W];
    end

    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == c_depth);
    // Commit is gated only by the registered head state, never by same-cycle
    // writebacks, so a writeback to the head cannot alter this cycle's commit.
    assign w_commit_valid = !w_empty && r_ready[r_head];
    assign w_commit_fire  = w_commit_valid && commit_ready;
    assign w_alloc_fire   = alloc_valid && !w_full && !flush;
    assign w_drain        = w_commit_fire && r_exc[r_head];

    assign alloc_ready  = !w_full;
    assign alloc_tag    = r_tail;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;

    assign commit_valid = w_commit_valid;
    assign commit_rd    = w_commit_valid ? r_rd[r_head]   : '0;
    assign commit_data  = w_commit_valid ? r_data[r_head] : '0;
    assign commit_pc    = w_commit_valid ? r_pc[r_head]   : '0;
    assign commit_tag   = w_commit_valid ? r_head         : '0;
    assign commit_exc   = w_commit_valid ? r_exc[r_head]  : 1'b0;

    // Scan ports from highest to lowest so the lowest matching port is
    // the last assignment and therefore takes priority.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_wb_hit[e] = 1'b0;
            w_wb_exc[e] = 1'b0;
            w_wb_val[e] = '0;
            for (int p = NUM_WB-1; p >= 0; p--) begin
                if (wb_valid[p] && (w_wb_tag[p] == IDX_W'(e))) begin
                    w_wb_hit[e] = 1'b1;
                    w_wb_exc[e] = wb_exc[p];
                    w_wb_val[e] = w_wb_dat[p];
                end
            end
        end
    end

    assign w_lk_tag[0] = rd_tag0;
    assign w_lk_tag[1] = rd_tag1;

    // Lookup: same-cycle writeback to a valid entry bypasses stored state.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_lk_rdy[l] = r_valid[w_lk_tag[l]] && r_ready[w_lk_tag[l]];
            w_lk_dat[l] = w_lk_rdy[l] ? r_data[w_lk_tag[l]] : '0;
            if (r_valid[w_lk_tag[l]] && w_wb_hit[w_lk_tag[l]]) begin
                w_lk_rdy[l] = 1'b1;
                w_lk_dat[l] = w_wb_val[w_lk_tag[l]];
            end
        end
    end

    assign rd_ready0 = w_lk_rdy[0];
    assign rd_ready1 = w_lk_rdy[1];
    assign rd_data0  = w_lk_dat[0];
    assign rd_data1  = w_lk_dat[1];

    always_ff @(posedge clk) begin
        if (!rst_n || flush || w_drain) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_ready <= '0;
            r_exc   <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wb_hit[e] && r_valid[e]) begin
                    r_ready[e] <= 1'b1;
                    r_exc[e]   <= w_wb_exc[e];
                    r_data[e]  <= w_wb_val[e];
                end
            end
            // Commit clear comes after writeback so it wins on the head entry.
            if (w_commit_fire) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + c_ptr_one;
            end
            // The tail entry is never valid when allocation fires, so no
            // writeback can target it this cycle.
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_exc[r_tail]   <= 1'b0;
                r_rd[r_tail]    <= alloc_rd;
                r_pc[r_tail]    <= alloc_pc;
                r_data[r_tail]  <= '0;
                r_tail          <= r_tail + c_ptr_one;
            end
            case ({w_alloc_fire, w_commit_fire})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer_mp
// Purpose  : Self-checking bench for reorder_buffer_mp. A queue-based model
//            tracks program order; directed scenarios are followed by
//            randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer_mp;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;
    localparam int NUM_WB = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [4:0]               alloc_rd;
    logic [31:0]              alloc_pc;
    logic [IDX_W-1:0]         alloc_tag;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB-1:0]        wb_exc;
    logic [NUM_WB*IDX_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic [IDX_W-1:0]         rd_tag0, rd_tag1;
    logic [DATA_W-1:0]        rd_data0, rd_data1;
    logic                     rd_ready0, rd_ready1;
    logic                     commit_valid;
    logic                     commit_ready;
    logic [4:0]               commit_rd;
    logic [DATA_W-1:0]        commit_data;
    logic [31:0]              commit_pc;
    logic [IDX_W-1:0]         commit_tag;
    logic                     commit_exc;
    logic                     flush;
    logic [IDX_W:0]           count;
    logic                     empty, full;

    reorder_buffer_mp #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_exc(wb_exc), .wb_tag(wb_tag), .wb_data(wb_data),
        .rd_tag0(rd_tag0), .rd_tag1(rd_tag1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rd(commit_rd), .commit_data(commit_data), .commit_pc(commit_pc),
        .commit_tag(commit_tag), .commit_exc(commit_exc),
        .flush(flush), .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-tag entry contents plus a queue of live tags
    // in program order. Head is the queue front, tail is m_tail.
    bit          m_valid [DEPTH];
    bit          m_ready [DEPTH];
    bit          m_exc   [DEPTH];
    logic [4:0]  m_rd    [DEPTH];
    logic [31:0] m_pc    [DEPTH];
    logic [31:0] m_data  [DEPTH];
    int          m_order [$];
    int          m_tail;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < DEPTH; e++) begin
            m_valid[e] = 0;
            m_ready[e] = 0;
            m_exc[e]   = 0;
        end
        m_order.delete();
        m_tail = 0;
    endtask

    function automatic int wtag(input int p);
        logic [NUM_WB*IDX_W-1:0] v;
        v = wb_tag;
        return int'(v[p*IDX_W +: IDX_W]);
    endfunction

    function automatic logic [31:0] wdat(input int p);
        logic [NUM_WB*DATA_W-1:0] v;
        v = wb_data;
        return v[p*DATA_W +: DATA_W];
    endfunction

    task automatic model_lookup(input int t, output bit r, output logic [31:0] d);
        r = 0;
        d = '0;
        if (m_valid[t] && m_ready[t]) begin
            r = 1;
            d = m_data[t];
        end
        if (m_valid[t]) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && wtag(p) == t) begin
                    r = 1;
                    d = wdat(p);
                    break;
                end
            end
        end
    endtask

    task automatic check_all();
        int          sz;
        int          h;
        bit          cv;
        bit          r;
        logic [31:0] d;
        sz = m_order.size();
        h  = (sz > 0) ? m_order[0] : 0;
        cv = (sz > 0) && m_ready[h];
        check("count", count, sz);
        check("empty", empty, sz == 0);
        check("full", full, sz == DEPTH);
        check("alloc_ready", alloc_ready, sz != DEPTH);
        check("alloc_tag", alloc_tag, m_tail);
        check("commit_valid", commit_valid, cv);
        check("commit_rd", commit_rd, cv ? m_rd[h] : 5'd0);
        check("commit_data", commit_data, cv ? m_data[h] : 32'd0);
        check("commit_pc", commit_pc, cv ? m_pc[h] : 32'd0);
        check("commit_tag", commit_tag, cv ? h : 0);
        check("commit_exc", commit_exc, cv ? m_exc[h] : 1'b0);
        model_lookup(int'(rd_tag0), r, d);
        check("rd_ready0", rd_ready0, r);
        check("rd_data0", rd_data0, d);
        model_lookup(int'(rd_tag1), r, d);
        check("rd_ready1", rd_ready1, r);
        check("rd_data1", rd_data1, d);
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        int sz;
        int h;
        bit cfire;
        sz    = m_order.size();
        h     = (sz > 0) ? m_order[0] : 0;
        cfire = (sz > 0) && m_ready[h] && commit_ready;
        if (!rst_n || flush || (cfire && m_exc[h])) begin
            model_clear();
            return;
        end
        for (int p = NUM_WB-1; p >= 0; p--) begin
            if (wb_valid[p] && m_valid[wtag(p)]) begin
                m_ready[wtag(p)] = 1;
                m_data[wtag(p)]  = wdat(p);
                m_exc[wtag(p)]   = wb_exc[p];
            end
        end
        if (cfire) begin
            m_valid[h] = 0;
            m_ready[h] = 0;
            void'(m_order.pop_front());
        end
        if (alloc_valid && sz < DEPTH) begin
            m_valid[m_tail] = 1;
            m_ready[m_tail] = 0;
            m_exc[m_tail]   = 0;
            m_rd[m_tail]    = alloc_rd;
            m_pc[m_tail]    = alloc_pc;
            m_data[m_tail]  = '0;
            m_order.push_back(m_tail);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    // Inputs are driven just after a falling edge; check, update model, edge.
    task automatic cycle();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst_n        = 1'b1;
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_rd     = 5'($urandom);
        alloc_pc     = $urandom;
        wb_valid     = '0;
        wb_exc       = '0;
        wb_tag       = '0;
        wb_data      = '0;
        commit_ready = 1'b0;
        rd_tag0      = '0;
        rd_tag1      = '0;
    endtask

    task automatic set_wb(input int p, input int t, input logic [31:0] d, input bit e);
        wb_valid[p]                 = 1'b1;
        wb_exc[p]                   = e;
        wb_tag[p*IDX_W +: IDX_W]    = IDX_W'(t);
        wb_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        idle();
        #1;
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_empty", empty, 1);
        check("rst_commit_valid", commit_valid, 0);
        cycle();

        // Fill to full with no writebacks; 17th allocation is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            commit_ready = 1'b1;
            alloc_valid  = 1'b1;
            alloc_rd     = 5'(i + 1);
            cycle();
        end
        idle();
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        #1;
        check("full_full", full, 1);
        check("full_alloc_ready", alloc_ready, 0);
        check("full_count", count, 16);
        check("full_commit_valid", commit_valid, 0);
        cycle();
        #1;
        check("full_tail_hold", alloc_tag, 0);
        check("full_count_hold", count, 16);

        // Out-of-order writeback, in-order commit.
        idle(); commit_ready = 1'b1; set_wb(0, 2, 32'hA2, 0); cycle();
        idle(); commit_ready = 1'b1; set_wb(0, 1, 32'hA1, 0); cycle();
        idle(); commit_ready = 1'b1; set_wb(0, 0, 32'hA0, 0);
        #1; check("ooo_no_commit", commit_valid, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle();
            commit_ready = 1'b1;
            #1;
            check("ooo_cv", commit_valid, 1);
            check("ooo_tag", commit_tag, i);
            check("ooo_data", commit_data, 32'hA0 + i);
            check("ooo_rd", commit_rd, i + 1);
            cycle();
        end

        // Two ports hit tag 3; port 0 wins both bypass and stored value.
        idle();
        set_wb(0, 3, 32'h11, 0);
        set_wb(1, 3, 32'h22, 0);
        rd_tag0 = 4'd3;
        #1;
        check("dual_bypass_rdy", rd_ready0, 1);
        check("dual_bypass_data", rd_data0, 32'h11);
        cycle();
        idle();
        rd_tag0 = 4'd3;
        #1;
        check("dual_stored_rdy", rd_ready0, 1);
        check("dual_stored_data", rd_data0, 32'h11);
        cycle();

        // Overwrite head with exception, then commit it alongside an alloc.
        idle(); set_wb(1, 3, 32'h33, 1); cycle();
        idle();
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        #1;
        check("exc_commit_exc", commit_exc, 1);
        check("exc_commit_data", commit_data, 32'h33);
        cycle();
        #1;
        check("exc_count", count, 0);
        check("exc_empty", empty, 1);
        check("exc_alloc_tag", alloc_tag, 0);
        check("exc_commit_valid", commit_valid, 0);

        // Wrap: fill, commit 4, allocate 4 more at tags 0..3.
        for (int i = 0; i < DEPTH; i++) begin
            idle(); alloc_valid = 1'b1; cycle();
        end
        idle(); set_wb(0, 0, 32'h100, 0); set_wb(1, 1, 32'h101, 0); cycle();
        idle(); set_wb(0, 2, 32'h102, 0); set_wb(1, 3, 32'h103, 0); cycle();
        for (int i = 0; i < 4; i++) begin
            idle(); commit_ready = 1'b1;
            #1; check("wrap_commit_tag", commit_tag, i);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            idle(); alloc_valid = 1'b1;
            #1; check("wrap_alloc_tag", alloc_tag, i);
            cycle();
        end
        #1; check("wrap_count", count, 16);
        for (int i = 0; i < DEPTH / 2; i++) begin
            idle();
            set_wb(0, 2 * i, $urandom, 0);
            set_wb(1, 2 * i + 1, $urandom, 0);
            cycle();
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(); commit_ready = 1'b1;
            #1;
            check("wrap_order_cv", commit_valid, 1);
            check("wrap_order_tag", commit_tag, (4 + i) % DEPTH);
            cycle();
        end

        // Flush with ready head still shows commit_valid that cycle.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); alloc_valid = 1'b1; cycle();
        end
        idle(); set_wb(0, 0, 32'h55, 0); set_wb(1, 1, 32'h66, 0); cycle();
        idle();
        flush        = 1'b1;
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        #1; check("flush_pre_cv", commit_valid, 1);
        cycle();
        #1;
        check("flush_count", count, 0);
        check("flush_tag", alloc_tag, 0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            idle(); alloc_valid = 1'b1; set_wb(0, i, $urandom, 0); cycle();
        end
        idle();
        rst_n        = 1'b0;
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        cycle();
        idle();
        #1;
        check("rst_mid_count", count, 0);
        check("rst_mid_cv", commit_valid, 0);
        check("rst_mid_rdy", rd_ready0, 0);
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int sz;
            idle();
            sz           = m_order.size();
            rst_n        = ($urandom_range(199) != 0);
            flush        = ($urandom_range(79) == 0);
            alloc_valid  = ($urandom_range(3) != 0);
            commit_ready = ($urandom_range(2) != 0);
            for (int p = 0; p < NUM_WB; p++) begin
                if ($urandom_range(1) == 1) begin
                    int t;
                    if (sz > 0 && $urandom_range(4) != 0)
                        t = m_order[$urandom_range(sz - 1)];
                    else
                        t = $urandom_range(DEPTH - 1);
                    set_wb(p, t, $urandom, $urandom_range(19) == 0);
                end
            end
            rd_tag0 = (sz > 0) ? IDX_W'(m_order[$urandom_range(sz - 1)]) : IDX_W'($urandom);
            rd_tag1 = IDX_W'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
